ivl_uvm_ovl_fire_collector: RTL and testbench
=============================================

Name: ivl_uvm_ovl_fire_collector

Overview:
- Consumer end of the OVL checker `fire` interface.
- Collects the fire vectors of NUM_CHK checkers and keeps, per checker, a saturating assertion-fail count.
- Latches sticky any-fail and first-failing-checker status.
- Queues timestamped fire events into a FIFO, drained by the UVM scoreboard over a valid/ready handshake.
- Sits beside the checkers in the test harness; all checkers share its clock and reset.

Parameters:
- NUM_CHK, 4, number of checkers observed; range 1..16.
- ID_W, 4, checker index width; must satisfy 2**ID_W >= NUM_CHK.
- CNT_W, 8, per-checker saturating fail counter width.
- TS_W, 16, timestamp counter width.
- DEPTH, 8, event FIFO depth; power of 2, >= 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = sample fire_in this cycle; 0 = ignore fire_in.
- clear  in  1  synchronous clear of collected state.
- fire_in  in  3*NUM_CHK  checker k drives bits [3k+2:3k]. Bit 0 = 2-state assertion fail, bit 1 = X-check fail, bit 2 = cover hit.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_id  out  ID_W  checker index of the head event.
- evt_type  out  2  0 = assert, 1 = xcheck, 2 = cover.
- evt_time  out  TS_W  timestamp of the head event.
- cnt_sel  in  ID_W  selects a counter to read.
- cnt_val  out  CNT_W  fail count of checker cnt_sel; combinational read, 0 if cnt_sel >= NUM_CHK.
- any_fail  out  1  sticky: some fire bit 0 was seen.
- first_id  out  ID_W  index of the first checker to assert fire bit 0; valid when any_fail = 1.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- drop_cnt  out  CNT_W  saturating count of events lost to arbitration or a full FIFO.

Behaviour:
- Reset (reset = 0, async): all outputs 0, FIFO empty, timestamp 0, all counters 0.
- Timestamp: free-running TS_W counter, increments every cycle after reset release. Wraps from 2**TS_W-1 to 0. Never affected by clear.
- Sampling: only when enable = 1 and clear = 0. A checker "fires" when any of its 3 bits is 1. fire_in X/Z bits are treated as 0.
- Counters: each cycle a checker's bit 0 = 1, its counter increments. Saturates at 2**CNT_W-1.
- any_fail / first_id: set on the first sampled bit 0. first_id takes the lowest index among the checkers failing that cycle. Held until clear or reset.
- Event selection: at most one event per cycle.
  - Winner is the lowest-index firing checker.
  - Its type is the lowest set bit: 0 before 1 before 2.
  - Each other firing checker that cycle increments drop_cnt by 1; the total increment is saturating.
  - The winner's event is {id, type, timestamp at the sampling edge}.
- FIFO push/pop:
  - Push a candidate event at the sampling edge.
  - Pop when evt_valid && evt_ready.
  - Output fields show the head entry; latency from fire_in to evt_valid is 1 cycle.
  - Full with no pop: the candidate is dropped, overflow is set, drop_cnt increments.
  - Full with a simultaneous pop: the push is accepted, no overflow.
  - Empty with a simultaneous push: evt_valid rises next cycle; no bypass.
- Handshake: while evt_valid = 1, the head fields stay stable until popped. evt_ready with evt_valid = 0 has no effect.
- clear = 1 (sync):
  - Next cycle: counters, any_fail, first_id, overflow and drop_cnt are 0, and the FIFO is empty.
  - fire_in in the same cycle is ignored; clear wins.
  - A pop in the same cycle is discarded.
- enable = 0: no counting and no events. The FIFO still drains.
- Reset asserted mid-drain: the FIFO is emptied immediately and evt_valid drops asynchronously.

Test Plan:
- Reset, enable = 1, fire_in = 0 for 10 cycles -> evt_valid = 0, any_fail = 0, cnt_val = 0 for all cnt_sel.
- Checker 2 bit 0 high for 3 cycles starting at timestamp 5, evt_ready = 1 -> three events {id 2, type 0, time 5/6/7}. cnt_sel = 2 gives cnt_val = 3, any_fail = 1, first_id = 2.
- Checkers 1 and 3 fire in the same cycle, checker 1 with bits 1 and 2 set -> one event {id 1, type 1}, drop_cnt = 1, first_id unchanged.
- evt_ready = 0, checker 0 fires 10 consecutive cycles with DEPTH = 8 -> 8 events queued, overflow = 1, drop_cnt = 2. Then evt_ready = 1 drains times in order, and evt_valid = 0 after 8 pops.
- Checker 0 fires 300 cycles with CNT_W = 8 -> cnt_val saturates at 255. Then clear, with a simultaneous fire -> all state 0, no event queued.
- enable = 0 with checker 1 firing -> no events, no count. Also run a TS_W = 4 build across a wrap: an event at timestamp 15 is followed by one at timestamp 0.

Source files
------------

// File: rtl/ivl_uvm_ovl_fire_collector.sv
// OVL fire collector: per-checker saturating fail counts, sticky first-fail status, and a timestamped event FIFO.
// Events reach evt_valid one cycle after sampling; a full FIFO with no pop drops the candidate and flags overflow.

module ivl_uvm_ovl_fire_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module ivl_uvm_ovl_fire_collector #(
  parameter int NUM_CHK = 4,
  parameter int ID_W    = 4,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [3*NUM_CHK-1:0] fire_in,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [ID_W-1:0]      evt_id,
  output logic [1:0]           evt_type,
  output logic [TS_W-1:0]      evt_time,
  input  logic [ID_W-1:0]      cnt_sel,
  output logic [CNT_W-1:0]     cnt_val,
  output logic                 any_fail,
  output logic [ID_W-1:0]      first_id,
  output logic                 overflow,
  output logic [CNT_W-1:0]     drop_cnt
);
  localparam int EW = ID_W + 2 + TS_W;
  localparam int SW = CNT_W + 7;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [TS_W-1:0]      ts_q, ts_d;
  logic [CNT_W-1:0]     cnt_q [NUM_CHK];
  logic [CNT_W-1:0]     cnt_d [NUM_CHK];
  logic                 any_fail_q, any_fail_d;
  logic [ID_W-1:0]      first_id_q, first_id_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic [3*NUM_CHK-1:0] fire_clean;
  logic                 sample;
  logic [NUM_CHK-1:0]   fires;
  logic [NUM_CHK-1:0]   fails;
  logic                 cand_vld;
  logic [ID_W-1:0]      cand_id;
  logic [1:0]           cand_type;
  logic                 fail_hit;
  logic [ID_W-1:0]      fail_id;
  logic [5:0]           n_fire;
  logic [5:0]           drop_inc;
  logic [SW-1:0]        drop_sum;
  logic                 pop;
  logic                 push_req;
  logic                 ovf_drop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [EW-1:0]        head_dat;
  logic [ID_W-1:0]      head_id;
  logic [1:0]           head_type;
  logic [TS_W-1:0]      head_time;

  assign sample = enable & ~clear;
  assign pop    = evt_valid & evt_ready;

  // Only a definite 1 counts as a fire; X/Z on a checker output is ignored.
  always_comb begin
    fire_clean = '0;
    for (int i = 0; i < 3*NUM_CHK; i++) begin
      fire_clean[i] = (fire_in[i] === 1'b1);
    end
  end

  always_comb begin
    fires     = '0;
    fails     = '0;
    cand_vld  = 1'b0;
    cand_id   = '0;
    cand_type = 2'd0;
    fail_hit  = 1'b0;
    fail_id   = '0;
    n_fire    = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      fires[k] = sample & (|fire_clean[3*k +: 3]);
      fails[k] = sample & fire_clean[3*k];
      n_fire   = n_fire + 6'(fires[k]);
    end
    // Walk downwards so the lowest index is the one left standing.
    for (int k = NUM_CHK - 1; k >= 0; k--) begin
      if (fires[k]) begin
        cand_vld = 1'b1;
        cand_id  = ID_W'(k);
        if (fire_clean[3*k])        cand_type = 2'd0;
        else if (fire_clean[3*k+1]) cand_type = 2'd1;
        else                        cand_type = 2'd2;
      end
      if (fails[k]) begin
        fail_hit = 1'b1;
        fail_id  = ID_W'(k);
      end
    end
  end

  always_comb begin
    push_req = cand_vld;
    ovf_drop = push_req & fifo_full & ~pop;
    drop_inc = n_fire - 6'(cand_vld) + 6'(ovf_drop);
    drop_sum = SW'(drop_cnt_q) + SW'(drop_inc);
    ts_d     = ts_q + 1'b1;
    if (clear) begin
      any_fail_d = 1'b0;
      first_id_d = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      any_fail_d = any_fail_q | fail_hit;
      first_id_d = (!any_fail_q && fail_hit) ? fail_id : first_id_q;
      overflow_d = overflow_q | ovf_drop;
      drop_cnt_d = (drop_sum > SW'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end
    for (int k = 0; k < NUM_CHK; k++) begin
      if (clear)                              cnt_d[k] = '0;
      else if (fails[k] && cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + 1'b1;
      else                                    cnt_d[k] = cnt_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      cnt_q      <= '{default: '0};
      any_fail_q <= 1'b0;
      first_id_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      cnt_q      <= cnt_d;
      any_fail_q <= any_fail_d;
      first_id_q <= first_id_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ivl_uvm_ovl_fire_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .flush    (clear),
    .push     (push_req),
    .push_dat ({cand_id, cand_type, ts_q}),
    .pop      (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign {head_id, head_type, head_time} = head_dat;

  // Head fields read as zero while empty so reset leaves every output at 0.
  assign evt_valid = ~fifo_empty;
  assign evt_id    = evt_valid ? head_id   : '0;
  assign evt_type  = evt_valid ? head_type : 2'd0;
  assign evt_time  = evt_valid ? head_time : '0;

  always_comb begin
    cnt_val = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      if (cnt_sel == ID_W'(k)) cnt_val = cnt_q[k];
    end
  end

  assign any_fail = any_fail_q;
  assign first_id = first_id_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_ivl_uvm_ovl_fire_collector.sv
// Scoreboard bench: stimulus queues expected events, negedge monitors pop and compare on each handshake.
module tb_ivl_uvm_ovl_fire_collector;
  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  typ;
    logic [15:0] tm;
  } evt_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable, clear, evt_ready;
  logic [11:0] fire_in;
  logic        evt_valid;
  logic [3:0]  evt_id;
  logic [1:0]  evt_type;
  logic [15:0] evt_time;
  logic [3:0]  cnt_sel;
  logic [7:0]  cnt_val;
  logic        any_fail;
  logic [3:0]  first_id;
  logic        overflow;
  logic [7:0]  drop_cnt;

  logic        t4_enable, t4_clear, t4_ready;
  logic [11:0] t4_fire;
  logic        t4_valid;
  logic [3:0]  t4_id;
  logic [1:0]  t4_type;
  logic [3:0]  t4_time;
  logic [3:0]  t4_cnt_sel;
  logic [7:0]  t4_cnt_val;
  logic        t4_any_fail;
  logic [3:0]  t4_first_id;
  logic        t4_overflow;
  logic [7:0]  t4_drop_cnt;

  int   checks = 0;
  int   failures = 0;
  int   ts_m = 0;
  evt_t exp_q[$];
  evt_t exp4_q[$];
  evt_t mon_e, mon4_e;

  always #5 clk = ~clk;

  ivl_uvm_ovl_fire_collector u_dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .fire_in(fire_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_type(evt_type),
    .evt_time(evt_time), .cnt_sel(cnt_sel), .cnt_val(cnt_val), .any_fail(any_fail),
    .first_id(first_id), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  ivl_uvm_ovl_fire_collector #(.TS_W(4)) u_dut_ts4 (
    .clk(clk), .reset(reset), .enable(t4_enable), .clear(t4_clear), .fire_in(t4_fire),
    .evt_valid(t4_valid), .evt_ready(t4_ready), .evt_id(t4_id), .evt_type(t4_type),
    .evt_time(t4_time), .cnt_sel(t4_cnt_sel), .cnt_val(t4_cnt_val), .any_fail(t4_any_fail),
    .first_id(t4_first_id), .overflow(t4_overflow), .drop_cnt(t4_drop_cnt)
  );

  // Reference timestamp: free-running from reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) ts_m <= 0;
    else        ts_m <= ts_m + 1;
  end

  always @(negedge clk) begin
    if (reset && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL evt_unexpected: got id=%0d type=%0d time=%0d, required no event", evt_id, evt_type, evt_time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({evt_id, evt_type, evt_time} !== {mon_e.id, mon_e.typ, mon_e.tm}) begin
          failures++;
          $display("FAIL evt_fields: got id=%0d type=%0d time=%0d, required id=%0d type=%0d time=%0d",
                   evt_id, evt_type, evt_time, mon_e.id, mon_e.typ, mon_e.tm);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && t4_valid && t4_ready) begin
      checks++;
      if (exp4_q.size() == 0) begin
        failures++;
        $display("FAIL ts4_unexpected: got id=%0d type=%0d time=%0d, required no event", t4_id, t4_type, t4_time);
      end else begin
        mon4_e = exp4_q.pop_front();
        if ({t4_id, t4_type, t4_time} !== {mon4_e.id, mon4_e.typ, mon4_e.tm[3:0]}) begin
          failures++;
          $display("FAIL ts4_fields: got id=%0d type=%0d time=%0d, required id=%0d type=%0d time=%0d",
                   t4_id, t4_type, t4_time, mon4_e.id, mon4_e.typ, mon4_e.tm[3:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input int sel, input logic [31:0] exp);
    cnt_sel = sel[3:0];
    #1;
    chk($sformatf("cnt_val[%0d]", sel), 32'(cnt_val), exp);
  endtask

  task automatic exp_push(input logic [3:0] id, input logic [1:0] t, input int tm);
    evt_t e;
    e.id  = id;
    e.typ = t;
    e.tm  = tm[15:0];
    exp_q.push_back(e);
  endtask

  task automatic exp4_push(input int tm);
    evt_t e;
    e.id  = 4'd0;
    e.typ = 2'd0;
    e.tm  = tm[15:0];
    exp4_q.push_back(e);
  endtask

  initial begin
    enable = 1'b1; clear = 1'b0; evt_ready = 1'b0; fire_in = '0; cnt_sel = '0;
    t4_enable = 1'b1; t4_clear = 1'b0; t4_ready = 1'b1; t4_fire = '0; t4_cnt_sel = '0;

    // Reset state
    step(); step();
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_evt_time", 32'(evt_time), 0);
    chk("rst_any_fail", 32'(any_fail), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    reset = 1'b1;
    evt_ready = 1'b1;
    repeat (10) step();
    chk("idle_evt_valid", 32'(evt_valid), 0);
    chk("idle_any_fail", 32'(any_fail), 0);
    for (int s = 0; s < 5; s++) chk_cnt(s, 0);

    // Restart the timestamp, then checker 2 asserts at times 5,6,7
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    repeat (5) step();
    fire_in = 12'h040;
    exp_push(4'd2, 2'd0, 5);
    #1;
    chk("no_bypass_valid", 32'(evt_valid), 0);
    step();
    chk("push_latency_valid", 32'(evt_valid), 1);
    exp_push(4'd2, 2'd0, 6);
    step();
    exp_push(4'd2, 2'd0, 7);
    step();
    fire_in = '0;
    repeat (3) step();
    chk_cnt(2, 3);
    chk_cnt(4, 0);
    chk("fail_any_fail", 32'(any_fail), 1);
    chk("fail_first_id", 32'(first_id), 2);

    // Checkers 1 (xcheck+cover) and 3 (assert) together
    fire_in = 12'h230;
    exp_push(4'd1, 2'd1, ts_m);
    step();
    fire_in = '0;
    repeat (3) step();
    chk("arb_drop_cnt", 32'(drop_cnt), 1);
    chk("arb_first_id", 32'(first_id), 2);
    chk_cnt(3, 1);
    chk_cnt(1, 0);

    // Overflow: fill with no consumer
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_drop_cnt", 32'(drop_cnt), 0);
    chk("clr_any_fail", 32'(any_fail), 0);
    chk_cnt(2, 0);
    evt_ready = 1'b0;
    fire_in = 12'h001;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_push(4'd0, 2'd0, ts_m);
      step();
    end
    fire_in = '0;
    chk("ovf_overflow", 32'(overflow), 1);
    chk("ovf_drop_cnt", 32'(drop_cnt), 2);
    chk("ovf_evt_valid", 32'(evt_valid), 1);
    chk("ovf_head_time", 32'(evt_time), 32'(exp_q[0].tm));
    chk_cnt(0, 10);
    step();
    chk("hold_head_time", 32'(evt_time), 32'(exp_q[0].tm));
    // Full with simultaneous pop: push accepted
    evt_ready = 1'b1;
    fire_in = 12'h001;
    exp_push(4'd0, 2'd0, ts_m);
    step();
    fire_in = '0;
    chk("fullpop_drop_cnt", 32'(drop_cnt), 2);
    repeat (12) step();
    chk("drain_evt_valid", 32'(evt_valid), 0);
    chk("drain_queue_empty", 32'(exp_q.size()), 0);

    // Counter saturation, then clear with a simultaneous fire
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_overflow", 32'(overflow), 0);
    fire_in = 12'h001;
    for (int i = 0; i < 300; i++) begin
      exp_push(4'd0, 2'd0, ts_m);
      step();
    end
    fire_in = '0;
    chk_cnt(0, 255);
    chk("sat_drop_cnt", 32'(drop_cnt), 0);
    repeat (3) step();
    clear = 1'b1;
    fire_in = 12'h001;
    step();
    clear = 1'b0;
    fire_in = '0;
    chk_cnt(0, 0);
    chk("clrfire_any_fail", 32'(any_fail), 0);
    chk("clrfire_evt_valid", 32'(evt_valid), 0);
    repeat (3) step();
    chk("clrfire_idle_valid", 32'(evt_valid), 0);

    // enable=0 ignores fires but the FIFO keeps draining
    evt_ready = 1'b0;
    fire_in = 12'h800;
    exp_push(4'd3, 2'd2, ts_m);
    step();
    exp_push(4'd3, 2'd2, ts_m);
    step();
    enable = 1'b0;
    evt_ready = 1'b1;
    fire_in = 12'h008;
    repeat (5) step();
    fire_in = '0;
    enable = 1'b1;
    step();
    chk_cnt(1, 0);
    chk_cnt(3, 0);
    chk("dis_any_fail", 32'(any_fail), 0);
    chk("dis_evt_valid", 32'(evt_valid), 0);
    chk("dis_queue_empty", 32'(exp_q.size()), 0);

    // Reset asserted while events are queued
    evt_ready = 1'b0;
    fire_in = 12'h001;
    exp_push(4'd0, 2'd0, ts_m);
    step();
    exp_push(4'd0, 2'd0, ts_m);
    step();
    fire_in = '0;
    chk("pre_rst_valid", 32'(evt_valid), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(evt_valid), 0);
    chk_cnt(0, 0);
    exp_q.delete();
    step(); step();
    reset = 1'b1;
    evt_ready = 1'b1;

    // TS_W=4 build: events at 15 then 0
    for (int g = 0; g < 40 && (ts_m & 15) != 15; g++) step();
    exp4_push(15);
    t4_fire = 12'h001;
    step();
    exp4_push(0);
    step();
    t4_fire = '0;
    repeat (4) step();
    chk("ts4_queue_empty", 32'(exp4_q.size()), 0);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
